// File: rtl/adc_bit_slicer_if.sv
// Sample-in / word-out bus for the ADC bit slicer.
// The slave side is the slicer; the master side is the sample source and word consumer.
interface adc_bit_slicer_if #(
  parameter int SAMPLE_W = 12,
  parameter int WORD_W   = 8
);
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_W-1:0]   out_data;

  modport master (
    output sample_valid, sample, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  sample_valid, sample, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/adc_bit_slicer.sv
// Hysteresis slicer plus bit-clock recovery: ADC samples in, LSB-first words out.
// The phase counter re-zeroes on every level edge and samples mid-bit.
module adc_bit_slicer #(
  parameter int SAMPLE_W   = 12,
  parameter int BIT_CYCLES = 10,
  parameter int WORD_W     = 8,
  parameter int THRESH_HI  = 2458,
  parameter int THRESH_LO  = 1638
) (
  input  logic             clk,
  input  logic             rst,
  adc_bit_slicer_if.slave  bus,
  output logic             level,
  output logic             locked,
  output logic             overflow
);
  localparam int PH_W = $clog2(BIT_CYCLES);
  localparam int BC_W = $clog2(WORD_W + 1);
  localparam logic [PH_W-1:0]     PH_MAX  = PH_W'(BIT_CYCLES - 1);
  localparam logic [PH_W-1:0]     PH_CAP  = PH_W'(BIT_CYCLES / 2);
  localparam logic [BC_W-1:0]     BC_LAST = BC_W'(WORD_W - 1);
  localparam logic [SAMPLE_W-1:0] TH_HI   = SAMPLE_W'(THRESH_HI);
  localparam logic [SAMPLE_W-1:0] TH_LO   = SAMPLE_W'(THRESH_LO);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              r_state, w_state_next;
  logic                r_level;
  logic [PH_W-1:0]     r_phase;
  logic [BC_W-1:0]     r_bitcnt;
  logic [WORD_W-1:0]   r_shift;
  logic                r_out_valid;
  logic [WORD_W-1:0]   r_out_data;
  logic                r_overflow;

  logic                w_level_next;
  logic                w_trans;
  logic [PH_W-1:0]     w_phase_next;
  logic                w_capture;
  logic                w_word_done;
  logic                w_hs;
  logic [WORD_W-1:0]   w_shift_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_trans) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  // Inside the hysteresis band the level simply holds.
  always_comb begin
    w_level_next = r_level;
    if (bus.sample >= TH_HI)      w_level_next = 1'b1;
    else if (bus.sample <= TH_LO) w_level_next = 1'b0;
  end

  assign w_trans = bus.sample_valid && (w_level_next != r_level);

  always_comb begin
    w_phase_next = r_phase;
    if (w_trans)
      w_phase_next = '0;
    else if (bus.sample_valid && r_state == RUN)
      w_phase_next = (r_phase == PH_MAX) ? '0 : r_phase + 1'b1;
  end

  assign w_capture   = bus.sample_valid && (r_state == RUN || w_trans) &&
                       (w_phase_next == PH_CAP);
  assign w_word_done = w_capture && (r_bitcnt == BC_LAST);
  assign w_hs        = r_out_valid && bus.out_ready;

  // New bits enter at the MSB so the first bit lands in bit 0 after WORD_W shifts.
  generate
    if (WORD_W == 1) begin : g_one
      assign w_shift_next = w_level_next;
    end else begin : g_many
      assign w_shift_next = {w_level_next, r_shift[WORD_W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level     <= 1'b0;
      r_phase     <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (bus.sample_valid) r_level <= w_level_next;
      r_phase <= w_phase_next;
      if (w_capture) begin
        r_shift  <= w_shift_next;
        r_bitcnt <= w_word_done ? '0 : r_bitcnt + 1'b1;
      end
      // A finished word only lands if the output slot is free or emptying this edge.
      if (w_word_done) begin
        if (!r_out_valid || w_hs) begin
          r_out_data  <= w_shift_next;
          r_out_valid <= 1'b1;
        end else begin
          r_overflow  <= 1'b1;
        end
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign level         = r_level;
  assign locked        = (r_state == RUN);
  assign overflow      = r_overflow;
endmodule

// File: doc/adc_bit_slicer.md
ADC_BIT_SLICER -- requirements
Module: adc_bit_slicer

Interface
REQ-001 Parameter SAMPLE_W, default 12: width of the unsigned ADC sample code.
REQ-002 Parameter BIT_CYCLES, default 10: valid samples per bit period, legal range 4..255.
REQ-003 Parameter WORD_W, default 8: bits per output word, legal range 1..64.
REQ-004 Parameter THRESH_HI, default 2458: rising threshold, sample >= THRESH_HI drives the slice level to 1.
REQ-005 Parameter THRESH_LO, default 1638: falling threshold, sample <= THRESH_LO drives the slice level to 0; THRESH_LO < THRESH_HI is required.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high. The ports are clk and rst.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 sample_valid  input  1  sample is a new ADC reading this cycle.
REQ-010 sample  input  SAMPLE_W  unsigned ADC code.
REQ-011 out_valid  output  1  out_data holds a completed word.
REQ-012 out_ready  input  1  consumer accepts the word.
REQ-013 out_data  output  WORD_W  recovered word, first received bit in bit 0.
REQ-014 level  output  1  current hysteresis-sliced level.
REQ-015 locked  output  1  a first level transition has been seen.
REQ-016 overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-017 When sample_valid=1, level_next SHALL be 1 if sample>=THRESH_HI, 0 if sample<=THRESH_LO, and level otherwise; when sample_valid=0, all state SHALL hold.
REQ-018 A transition is defined as sample_valid=1 with level_next != level.
REQ-019 The FSM SHALL have two states: IDLE (locked=0) and RUN (locked=1); IDLE->RUN on the first transition; RUN SHALL persist until rst.
REQ-020 Phase counter: on a transition it SHALL load 0; otherwise, in RUN on a valid sample, it SHALL increment, wrapping BIT_CYCLES-1 -> 0.
REQ-021 Bit capture SHALL occur on a valid sample in RUN, or on the locking transition, whose post-update phase equals BIT_CYCLES/2 (integer division); the captured value is level_next.
REQ-022 When BIT_CYCLES/2 = 0 the capture rule SHALL not be reachable; the legal range in REQ-002 prevents this.
REQ-023 Captured bits SHALL be shifted in LSB-first; a bit counter SHALL count 0..WORD_W-1.
REQ-024 On the WORD_W-th capture the word SHALL be loaded into out_data, with out_valid=1 from the next cycle; the bit counter SHALL return to 0.
REQ-025 out_valid and out_data SHALL remain stable until a cycle with out_valid=1 and out_ready=1; out_valid SHALL deassert the following cycle unless a new word loads on that same edge.
REQ-026 A word completing while out_valid=1 and out_ready=0 SHALL be dropped, overflow SHALL set, and out_data SHALL be unchanged.
REQ-027 A word completing in the same cycle as an accepting handshake SHALL load, with out_valid remaining 1 and no overflow.
REQ-028 overflow SHALL clear only on rst.
REQ-029 Transitions in RUN SHALL resynchronise the phase only; the bit counter and partial word SHALL be unaffected.
REQ-030 level and locked SHALL be registered, updated on the edge that processes the sample.

Reset
REQ-031 While rst=1 at a clock edge, the block SHALL set: level=0, locked=0 (IDLE), phase=0, bit counter=0, shift register=0, out_valid=0, out_data=0, overflow=0.
REQ-032 rst asserted mid-word or with out_valid=1 SHALL discard all partial and pending data; sample_valid SHALL be ignored during reset.

Verification
REQ-033 Stimulus after reset: 10 samples of 0, then alternating blocks of 10 samples of 4095 and 10 samples of 0 (BIT_CYCLES=10), out_ready=1 -> locked=1 after the first 4095; exactly one word 0x55 is emitted after 80 high/low samples; overflow=0.
REQ-034 Samples oscillating between 1800 and 2300 only (inside the hysteresis band) -> level, locked, and out_valid stay 0.
REQ-035 Same bit stream as REQ-033 with out_ready=0 for 200 cycles -> first word 0x55 is held stable; the second word is dropped; overflow=1 and stays 1; raising out_ready yields a single handshake of 0x55.
REQ-036 Same bit stream with sample_valid low every other cycle -> the same 0x55 word results, output timing stretched, with no extra captures.
REQ-037 rst pulsed after 4 bits of a word -> all outputs are zero next cycle; the restarted stream produces a correct word with no residual bits.
REQ-038 Bit period jittered to 9 and 11 samples -> the phase resync recovers 0x55 without error.
